// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, redirect kinds
// (ordered so a larger value means a higher-priority redirect) and the PC step.
package pc_seq_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, ADVANCE, HOLD} state_e;

  typedef enum logic [1:0] {RD_NONE, RD_BRANCH, RD_JUMP, RD_EXC} redir_e;

  localparam logic [31:0] PC_INCR = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_sel.sv
// Combinational next-PC selection: resolves the live redirect, arbitrates it
// against a pending one (equal priority favours the live, newer target).
module next_pc_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_ADDR = 32'h0000_0080
) (
  input  logic [31:0] pc_i,
  input  logic        exception_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  redir_e      pend_kind_i,
  input  logic [31:0] pend_target_i,
  input  logic        stall_i,
  output redir_e      live_kind_o,
  output logic [31:0] live_target_o,
  output logic [31:0] next_pc_o,
  output logic        load_en_o
);

  redir_e      live_kind;
  logic [31:0] live_target;
  redir_e      sel_kind;
  logic [31:0] sel_target;

  always_comb begin
    live_kind   = RD_NONE;
    live_target = '0;
    if (exception_i) begin
      live_kind   = RD_EXC;
      live_target = EXC_ADDR;
    end else if (jump_i) begin
      live_kind   = RD_JUMP;
      live_target = jump_target_i;
    end else if (branch_taken_i) begin
      live_kind   = RD_BRANCH;
      live_target = branch_target_i;
    end
    live_target = word_align(live_target);

    if (live_kind != RD_NONE && live_kind >= pend_kind_i) begin
      sel_kind   = live_kind;
      sel_target = live_target;
    end else begin
      sel_kind   = pend_kind_i;
      sel_target = pend_target_i;
    end

    // Any redirect beats stall; otherwise stall holds and no-stall steps by 4.
    load_en_o     = (sel_kind != RD_NONE) || !stall_i;
    next_pc_o     = (sel_kind != RD_NONE) ? sel_target : pc_i + PC_INCR;
    live_kind_o   = live_kind;
    live_target_o = live_target;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch FSM owning the PC, the pending-redirect register and (with
// PC_EXC_VECTOR_EN defined) the exception vector and epc capture.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] EXC_ADDR   = 32'h0000_0080
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
`ifdef PC_EXC_VECTOR_EN
  input  logic        exception_i,
  output logic [31:0] epc_o,
`endif
  input  logic        fetch_ack_i,
  output logic [31:0] inst_address_o,
  output logic        fetch_req_o,
  output logic        inst_valid_o
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic        fetch_req_q;
  logic        inst_valid_q;
  redir_e      pend_kind_q, pend_kind_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        exc_live;
  redir_e      live_kind;
  logic [31:0] live_target;
  logic [31:0] next_pc;
  logic        load_en;

`ifdef PC_EXC_VECTOR_EN
  logic [31:0] epc_q;
  assign exc_live = exception_i;
  assign epc_o    = epc_q;
`else
  assign exc_live = 1'b0;
`endif

  next_pc_sel #(.EXC_ADDR(EXC_ADDR)) u_sel (
    .pc_i           (pc_q),
    .exception_i    (exc_live),
    .jump_i         (jump_i),
    .jump_target_i  (jump_target_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .pend_kind_i    (pend_kind_q),
    .pend_target_i  (pend_tgt_q),
    .stall_i        (stall_i),
    .live_kind_o    (live_kind),
    .live_target_o  (live_target),
    .next_pc_o      (next_pc),
    .load_en_o      (load_en)
  );

  // Redirects seen during FETCH are parked; the stronger (or newer equal) one wins.
  always_comb begin
    pend_kind_d = pend_kind_q;
    pend_tgt_d  = pend_tgt_q;
    if (state_q == FETCH && live_kind != RD_NONE && live_kind >= pend_kind_q) begin
      pend_kind_d = live_kind;
      pend_tgt_d  = live_target;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_ADDR;
      fetch_req_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      pend_kind_q  <= RD_NONE;
      pend_tgt_q   <= '0;
`ifdef PC_EXC_VECTOR_EN
      epc_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= FETCH;
          fetch_req_q <= 1'b1;
        end
        FETCH: begin
          pend_kind_q <= pend_kind_d;
          pend_tgt_q  <= pend_tgt_d;
          if (fetch_ack_i) begin
            state_q      <= ADVANCE;
            fetch_req_q  <= 1'b0;
            inst_valid_q <= (pend_kind_d == RD_NONE);
          end
        end
        ADVANCE, HOLD: begin
          inst_valid_q <= 1'b0;
          pend_kind_q  <= RD_NONE;
          if (load_en) begin
            state_q     <= FETCH;
            pc_q        <= next_pc;
            fetch_req_q <= 1'b1;
`ifdef PC_EXC_VECTOR_EN
            if (live_kind == RD_EXC || pend_kind_q == RD_EXC) epc_q <= pc_q;
`endif
          end else begin
            state_q <= HOLD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst_address_o = pc_q;
  assign fetch_req_o    = fetch_req_q;
  assign inst_valid_o   = inst_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer; the model tracks the
// expected PC per instruction from the redirect-priority rules.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] bt = '0;
  logic        jmp = 1'b0;
  logic [31:0] jt = '0;
  logic        ack = 1'b0;
  logic [31:0] addr;
  logic        req;
  logic        valid;
`ifdef PC_EXC_VECTOR_EN
  logic        exc = 1'b0;
  logic [31:0] epc;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_epc = '0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .stall_i        (stall),
    .branch_taken_i (br),
    .branch_target_i(bt),
    .jump_i         (jmp),
    .jump_target_i  (jt),
`ifdef PC_EXC_VECTOR_EN
    .exception_i    (exc),
    .epc_o          (epc),
`endif
    .fetch_ack_i    (ack),
    .inst_address_o (addr),
    .fetch_req_o    (req),
    .inst_valid_o   (valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    stall = 1'b0; br = 1'b0; jmp = 1'b0; ack = 1'b0;
`ifdef PC_EXC_VECTOR_EN
    exc = 1'b0;
`endif
  endtask

  // One instruction, entered at a negedge while the DUT sits in FETCH.
  // fk: redirect raised during FETCH (0 none, 1 branch, 2 jump) to target ft.
  task automatic run_instr(input int waits, input int fk, input logic [31:0] ft,
                           input int stall_cyc, input bit aexc, input bit ajmp,
                           input logic [31:0] ajt, input bit abr, input logic [31:0] abt);
    int          live_rank;
    logic [31:0] live_t;
    logic [31:0] nxt;
    bit          e;
    chk("fetch_req", {31'b0, req}, 32'd1);
    chk("fetch_addr", addr, exp_pc);
    chk("fetch_valid", {31'b0, valid}, 32'd0);
    ack = (waits == 0);
    br = (fk == 1); jmp = (fk == 2); bt = ft; jt = ft;
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      br = 1'b0; jmp = 1'b0;
      chk("wait_req", {31'b0, req}, 32'd1);
      chk("wait_addr", addr, exp_pc);
      ack = (w == waits - 1);
    end
    @(negedge clk);
    ack = 1'b0;
    chk("adv_valid", {31'b0, valid}, (fk == 0) ? 32'd1 : 32'd0);
    chk("adv_req", {31'b0, req}, 32'd0);
    chk("adv_addr", addr, exp_pc);
    stall = (stall_cyc > 0);
    br = abr; bt = abt; jmp = ajmp; jt = ajt;
`ifdef PC_EXC_VECTOR_EN
    exc = aexc;
    e = aexc;
`else
    e = 1'b0;
`endif
    live_rank = e ? 3 : ajmp ? 2 : abr ? 1 : 0;
    live_t    = e ? 32'h80 : ajmp ? ajt : abt;
    if (live_rank > 0 && live_rank >= fk) nxt = live_t & ~32'd3;
    else if (fk > 0) nxt = ft & ~32'd3;
    else nxt = exp_pc + 32'd4;
    if (e) exp_epc = exp_pc;
    if (live_rank == 0 && fk == 0 && stall_cyc > 0) begin
      for (int h = 0; h < stall_cyc; h++) begin
        @(negedge clk);
        chk("hold_req", {31'b0, req}, 32'd0);
        chk("hold_valid", {31'b0, valid}, 32'd0);
        chk("hold_addr", addr, exp_pc);
        stall = (h < stall_cyc - 1);
      end
    end
    @(negedge clk);
    clear_inputs();
    exp_pc = nxt;
`ifdef PC_EXC_VECTOR_EN
    chk("epc", epc, exp_epc);
`endif
  endtask

  initial begin
    int r, fk, sc;
    repeat (3) @(negedge clk);
    chk("rst_addr", addr, 32'h0);
    chk("rst_req", {31'b0, req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
`ifdef PC_EXC_VECTOR_EN
    chk("rst_epc", epc, 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);
    exp_pc = 32'h0;

    repeat (4) run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 4, 0, 0, 0, 0, 0);
    chk("after_stall_pc", exp_pc, 32'h14);
    run_instr(2, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 1, 32'h100, 1, 32'h40);
    chk("jump_wins", addr, 32'h100);
    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 32'h20);
    run_instr(0, 0, 0, 0, 0, 0, 0, 1, 32'h43);
    chk("branch_align", addr, 32'h40);
    run_instr(0, 0, 0, 0, 0, 1, 32'h30, 0, 0);
    run_instr(1, 1, 32'h200, 0, 0, 0, 0, 0, 0);
    chk("fetch_branch", addr, 32'h200);
    run_instr(0, 0, 0, 0, 0, 1, 32'h50, 0, 0);
    run_instr(0, 0, 0, 1, 1, 1, 32'h300, 0, 0);
    run_instr(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_pc", addr, 32'h0);
    run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; ack = 1'b1;
    @(negedge clk);
    chk("midrst_addr", addr, 32'h0);
    chk("midrst_req", {31'b0, req}, 32'd0);
    chk("midrst_valid", {31'b0, valid}, 32'd0);
    rst = 1'b0; ack = 1'b0;
    exp_pc = 32'h0; exp_epc = 32'h0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      r  = $urandom_range(0, 9);
      fk = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      sc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_instr($urandom_range(0, 3), fk, $urandom, sc,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0), $urandom,
                ($urandom_range(0, 4) == 0), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
